// File: rtl/video_pkg.sv
// Shared definitions for the video sync decoder: widths, FSM encoding, CRC constants
// and the saturating / CRC step helpers used by the datapath.
package video_pkg;

    localparam int COORD_W = 16;
    localparam int COLOR_W = 4;
    localparam int PIXEL_W = 3 * COLOR_W;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } sync_state_e;

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // One pixel word per call, MSB first, non-reflected CCITT form.
    function automatic logic [15:0] crc16_step(input logic [15:0]        crc,
                                               input logic [PIXEL_W-1:0] word);
        logic [15:0] c;
        c = crc;
        for (int i = PIXEL_W - 1; i >= 0; i--) begin
            if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/video_frame_crc.sv
// Per-frame CRC-16 accumulator over active pixels; result latched on each frame edge.
// Only instantiated when VIDEO_SYNC_DECODER_CRC_EN is defined.
module video_frame_crc
    import video_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_vld,
    input  logic [PIXEL_W-1:0] pix,
    input  logic               frame_edge,
    output logic [15:0]        frame_crc,
    output logic               frame_crc_valid
);

    logic [15:0] acc_q, acc_d;
    logic [15:0] crc_q, crc_d;
    logic        vld_q, vld_d;
    logic [15:0] seed;

    always_comb begin
        // A pixel coincident with the frame edge starts the new frame's CRC.
        seed  = frame_edge ? CRC_INIT : acc_q;
        acc_d = pix_vld ? crc16_step(seed, pix) : seed;
        crc_d = frame_edge ? acc_q : crc_q;
        vld_d = frame_edge;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= CRC_INIT;
            crc_q <= '0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            crc_q <= crc_d;
            vld_q <= vld_d;
        end
    end

    assign frame_crc       = crc_q;
    assign frame_crc_valid = vld_q;

endmodule

// File: rtl/video_sync_decoder.sv
// Recovers x/y for a raw sync/de/RGB stream, measures active geometry and declares lock.
// Optional per-frame CRC output enabled by VIDEO_SYNC_DECODER_CRC_EN.
module video_sync_decoder
    import video_pkg::*;
#(
    parameter bit HSYNC_ACTIVE_HIGH = 1'b1,
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
    parameter int LOCK_FRAMES       = 2,
    parameter int TIMEOUT_LOG2      = 22
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               de,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pixel_valid,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               frame_start,
    output logic [COORD_W-1:0] active_width,
    output logic [COORD_W-1:0] active_height,
    output logic               locked
`ifdef VIDEO_SYNC_DECODER_CRC_EN
    ,
    output logic [15:0]        frame_crc,
    output logic               frame_crc_valid
`endif
);

    localparam logic [COORD_W-1:0] LOCK_TARGET = 16'(LOCK_FRAMES - 1);

    logic               hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d, de_p1_q, de_p1_d;
    logic [PIXEL_W-1:0] rgb_p1_q, rgb_p1_d;
    logic               vs_p2_q, vs_p2_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               pv_q, pv_d, fs_q, fs_d;
    logic [PIXEL_W-1:0] rgb_q, rgb_d;
    logic [COORD_W-1:0] line_cnt_q, line_cnt_d, first_len_q, first_len_d;
    logic               first_seen_q, first_seen_d, incons_q, incons_d;
    logic [COORD_W-1:0] cand_w_q, cand_w_d, cand_h_q, cand_h_d;
    logic [COORD_W-1:0] match_cnt_q, match_cnt_d;
    logic [COORD_W-1:0] aw_q, aw_d, ah_q, ah_d;
    logic               locked_q, locked_d;
    logic [TIMEOUT_LOG2-1:0] tmo_q, tmo_d;
    sync_state_e        state_q, state_d;

    logic               vs_edge, de_fall, tmo_expired;
    logic [COORD_W-1:0] line_len, frame_w, frame_h;
    logic               frame_valid, frame_match, lock_now, lock_lost;
    logic               unused_hsync;

    assign unused_hsync = hs_p1_q;

    // Stage 1 -> stage 2 boundary: event detection on the registered, polarity-normalised inputs.
    assign vs_edge     = vs_p1_q & ~vs_p2_q;
    assign de_fall     = pv_q & ~de_p1_q;
    assign line_len    = sat_inc(x_q);
    assign tmo_expired = (tmo_q == '1) & ~vs_edge;

    // A line ending on the vsync edge still belongs to the frame being closed.
    assign frame_w     = first_seen_q ? first_len_q : (de_fall ? line_len : '0);
    assign frame_h     = de_fall ? sat_inc(line_cnt_q) : line_cnt_q;
    assign frame_valid = ~(incons_q | (de_fall & first_seen_q & (line_len != first_len_q)))
                         & (frame_w != '0) & (frame_h != '0);
    assign frame_match = frame_valid & (frame_w == cand_w_q) & (frame_h == cand_h_q);
    assign lock_now    = (LOCK_FRAMES == 1) ? frame_valid
                                            : (frame_match & (sat_inc(match_cnt_q) == LOCK_TARGET));
    assign lock_lost   = tmo_expired | (de_fall & (line_len != aw_q)) | (vs_edge & (frame_h != ah_q));

    always_comb begin
        hs_p1_d  = HSYNC_ACTIVE_HIGH ? hsync : ~hsync;
        vs_p1_d  = VSYNC_ACTIVE_HIGH ? vsync : ~vsync;
        de_p1_d  = de;
        rgb_p1_d = {r_in, g_in, b_in};
        vs_p2_d  = vs_p1_q;

        x_d   = de_p1_q ? (pv_q ? sat_inc(x_q) : '0) : x_q;
        y_d   = de_p1_q ? (vs_edge ? '0 : line_cnt_q) : y_q;
        pv_d  = de_p1_q;
        rgb_d = de_p1_q ? rgb_p1_q : '0;
        fs_d  = vs_edge;

        line_cnt_d   = vs_edge ? '0 : (de_fall ? sat_inc(line_cnt_q) : line_cnt_q);
        tmo_d        = vs_edge ? '0 : tmo_q + 1'b1;
        first_len_d  = first_len_q;
        first_seen_d = first_seen_q;
        incons_d     = incons_q;
        if (de_fall) begin
            if (!first_seen_q) begin
                first_len_d  = line_len;
                first_seen_d = 1'b1;
            end else if (line_len != first_len_q) begin
                incons_d = 1'b1;
            end
        end
        if (vs_edge) begin
            first_len_d  = '0;
            first_seen_d = 1'b0;
            incons_d     = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        locked_d    = locked_q;
        aw_d        = aw_q;
        ah_d        = ah_q;
        cand_w_d    = cand_w_q;
        cand_h_d    = cand_h_q;
        match_cnt_d = match_cnt_q;
        case (state_q)
            SEARCH: begin
                if (vs_edge) begin
                    state_d     = MEASURE;
                    cand_w_d    = '0;
                    cand_h_d    = '0;
                    match_cnt_d = '0;
                end
            end
            MEASURE: begin
                if (tmo_expired) begin
                    state_d = SEARCH;
                end else if (vs_edge) begin
                    if (lock_now) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        aw_d     = frame_w;
                        ah_d     = frame_h;
                    end else if (frame_match) begin
                        match_cnt_d = sat_inc(match_cnt_q);
                    end else begin
                        cand_w_d    = frame_w;
                        cand_h_d    = frame_h;
                        match_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (lock_lost) begin
                    state_d  = SEARCH;
                    locked_d = 1'b0;
                end
            end
            default: begin
                state_d  = SEARCH;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_p1_q      <= 1'b0;
            vs_p1_q      <= 1'b0;
            de_p1_q      <= 1'b0;
            rgb_p1_q     <= '0;
            vs_p2_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            pv_q         <= 1'b0;
            rgb_q        <= '0;
            fs_q         <= 1'b0;
            line_cnt_q   <= '0;
            first_len_q  <= '0;
            first_seen_q <= 1'b0;
            incons_q     <= 1'b0;
            cand_w_q     <= '0;
            cand_h_q     <= '0;
            match_cnt_q  <= '0;
            aw_q         <= '0;
            ah_q         <= '0;
            locked_q     <= 1'b0;
            tmo_q        <= '0;
            state_q      <= SEARCH;
        end else begin
            hs_p1_q      <= hs_p1_d;
            vs_p1_q      <= vs_p1_d;
            de_p1_q      <= de_p1_d;
            rgb_p1_q     <= rgb_p1_d;
            vs_p2_q      <= vs_p2_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pv_q         <= pv_d;
            rgb_q        <= rgb_d;
            fs_q         <= fs_d;
            line_cnt_q   <= line_cnt_d;
            first_len_q  <= first_len_d;
            first_seen_q <= first_seen_d;
            incons_q     <= incons_d;
            cand_w_q     <= cand_w_d;
            cand_h_q     <= cand_h_d;
            match_cnt_q  <= match_cnt_d;
            aw_q         <= aw_d;
            ah_q         <= ah_d;
            locked_q     <= locked_d;
            tmo_q        <= tmo_d;
            state_q      <= state_d;
        end
    end

    assign x             = x_q;
    assign y             = y_q;
    assign pixel_valid   = pv_q;
    assign {r, g, b}     = rgb_q;
    assign frame_start   = fs_q;
    assign active_width  = aw_q;
    assign active_height = ah_q;
    assign locked        = locked_q;

`ifdef VIDEO_SYNC_DECODER_CRC_EN
    video_frame_crc u_crc (
        .clk             (clk),
        .reset           (reset),
        .pix_vld         (de_p1_q),
        .pix             (rgb_p1_q),
        .frame_edge      (vs_edge),
        .frame_crc       (frame_crc),
        .frame_crc_valid (frame_crc_valid)
    );
`endif

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed bench for video_sync_decoder: geometry lock, pixel path, relock, polarity,
// timeout and asynchronous reset; CRC checks when VIDEO_SYNC_DECODER_CRC_EN is defined.
module tb_video_sync_decoder;
    import video_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, hsync, vsync, de;
    logic [3:0] r_in, g_in, b_in;

    logic [15:0] m_x, m_y, m_aw, m_ah, p_x, p_y, p_aw, p_ah, t_x, t_y, t_aw, t_ah;
    logic        m_pv, m_fs, m_locked, p_pv, p_fs, p_locked, t_pv, t_fs, t_locked;
    logic [3:0]  m_r, m_g, m_b, p_r, p_g, p_b, t_r, t_g, t_b;
`ifdef VIDEO_SYNC_DECODER_CRC_EN
    logic [15:0] m_crc, p_crc, t_crc;
    logic        m_crcv, p_crcv, t_crcv;
    logic [15:0] crc_fs, crc_ref;
    logic        crcv_pre, crcv_fs;
`endif

    video_sync_decoder #(.HSYNC_ACTIVE_HIGH(1), .VSYNC_ACTIVE_HIGH(1), .LOCK_FRAMES(2), .TIMEOUT_LOG2(22)) u_main (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .de(de),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .x(m_x), .y(m_y), .pixel_valid(m_pv),
        .r(m_r), .g(m_g), .b(m_b), .frame_start(m_fs), .active_width(m_aw),
        .active_height(m_ah), .locked(m_locked)
`ifdef VIDEO_SYNC_DECODER_CRC_EN
        , .frame_crc(m_crc), .frame_crc_valid(m_crcv)
`endif
    );

    video_sync_decoder #(.HSYNC_ACTIVE_HIGH(0), .VSYNC_ACTIVE_HIGH(0), .LOCK_FRAMES(2), .TIMEOUT_LOG2(22)) u_pol (
        .clk(clk), .reset(reset), .hsync(~hsync), .vsync(~vsync), .de(de),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .x(p_x), .y(p_y), .pixel_valid(p_pv),
        .r(p_r), .g(p_g), .b(p_b), .frame_start(p_fs), .active_width(p_aw),
        .active_height(p_ah), .locked(p_locked)
`ifdef VIDEO_SYNC_DECODER_CRC_EN
        , .frame_crc(p_crc), .frame_crc_valid(p_crcv)
`endif
    );

    video_sync_decoder #(.HSYNC_ACTIVE_HIGH(1), .VSYNC_ACTIVE_HIGH(1), .LOCK_FRAMES(2), .TIMEOUT_LOG2(6)) u_tmo (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .de(de),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .x(t_x), .y(t_y), .pixel_valid(t_pv),
        .r(t_r), .g(t_g), .b(t_b), .frame_start(t_fs), .active_width(t_aw),
        .active_height(t_ah), .locked(t_locked)
`ifdef VIDEO_SYNC_DECODER_CRC_EN
        , .frame_crc(t_crc), .frame_crc_valid(t_crcv)
`endif
    );

    int checks   = 0;
    int failures = 0;

    int          pix_cnt = 0, fall_cnt = 0;
    logic        tgt_en = 1'b0;
    logic        lk_pre, lk_fs, fs_obs, pv_fs, plk_pre, plk_fs, tlk_fs;
    logic [11:0] rgb_fs;
    logic [15:0] pix_x, pix_y;
    logic [3:0]  pix_r, pix_g, pix1_r;
    logic        pix_pv, lk_f1, lk_f2;
    logic [1:0]  st_f2, st_now;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vsync occupies line 0; active lines start at line 2, active pixels at column 2.
    task automatic send_frame(input int w, input int h, input int lclk, input int nlines,
                              input int short_line, input logic [11:0] col);
        for (int ln = 0; ln < nlines; ln++) begin
            for (int c = 0; c < lclk; c++) begin
                int al;
                int len;
                al  = ln - 2;
                len = (short_line >= 0 && al == short_line) ? w - 1 : w;
                vsync = (ln == 0);
                hsync = (c == 0);
                de    = (al >= 0) && (al < h) && (c >= 2) && (c < 2 + len);
                {r_in, g_in, b_in} = de ? col : 12'h000;
                if (tgt_en && de && al == 2 && c == 7) begin
                    r_in    = 4'hA;
                    pix_cnt = 2;
                end
                if (short_line >= 0 && al == short_line && c == 2 + len) fall_cnt = 2;
                tick();
                if (ln == 0 && c == 0) begin
                    lk_pre  = m_locked;
                    plk_pre = p_locked;
`ifdef VIDEO_SYNC_DECODER_CRC_EN
                    crcv_pre = m_crcv;
`endif
                end
                if (ln == 0 && c == 1) begin
                    fs_obs = m_fs;
                    lk_fs  = m_locked;
                    plk_fs = p_locked;
                    tlk_fs = t_locked;
                    rgb_fs = {m_r, m_g, m_b};
                    pv_fs  = m_pv;
`ifdef VIDEO_SYNC_DECODER_CRC_EN
                    crcv_fs = m_crcv;
                    crc_fs  = m_crc;
`endif
                end
                if (pix_cnt > 0) begin
                    pix_cnt--;
                    if (pix_cnt == 1) pix1_r = m_r;
                    else begin
                        pix_x = m_x; pix_y = m_y; pix_r = m_r; pix_g = m_g; pix_pv = m_pv;
                    end
                end
                if (fall_cnt > 0) begin
                    fall_cnt--;
                    if (fall_cnt == 1) lk_f1 = m_locked;
                    else begin
                        lk_f2 = m_locked;
                        st_f2 = u_main.state_q;
                    end
                end
            end
        end
    endtask

`ifdef VIDEO_SYNC_DECODER_CRC_EN
    function automatic logic [15:0] ref_crc_zero(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < n * 12; k++) begin
            logic fb;
            fb = c[15];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        r_in = 4'h0; g_in = 4'h0; b_in = 4'h0;
        tick(); tick(); tick();
        chk("rst_x", m_x, 16'd0);
        chk("rst_locked", 16'(m_locked), 16'd0);
        chk("rst_fs", 16'(m_fs), 16'd0);
        chk("rst_aw", m_aw, 16'd0);
        chk("rst_pv", 16'(m_pv), 16'd0);
        chk("rst_pol_locked", 16'(p_locked), 16'd0);
        reset = 1'b0;
        tick();

        // 8x4 active, 12 clocks/line, 7 lines/frame
        send_frame(8, 4, 12, 7, -1, 12'h123);
        chk("f1_frame_start", 16'(fs_obs), 16'd1);
        chk("f1_locked", 16'(lk_fs), 16'd0);

        tgt_en = 1'b1;
        send_frame(8, 4, 12, 7, -1, 12'h123);
        tgt_en = 1'b0;
        chk("f2_locked", 16'(lk_fs), 16'd0);
        chk("blank_rgb", 16'(rgb_fs), 16'd0);
        chk("blank_pv", 16'(pv_fs), 16'd0);
        chk("pix_prev_r", 16'(pix1_r), 16'h1);
        chk("pix_x", pix_x, 16'd5);
        chk("pix_y", pix_y, 16'd2);
        chk("pix_r", 16'(pix_r), 16'hA);
        chk("pix_g", 16'(pix_g), 16'h2);
        chk("pix_pv", 16'(pix_pv), 16'd1);

        send_frame(8, 4, 12, 7, -1, 12'h123);
        chk("f3_locked_before_fs", 16'(lk_pre), 16'd0);
        chk("f3_locked_with_fs", 16'(lk_fs), 16'd1);
        chk("f3_aw", m_aw, 16'd8);
        chk("f3_ah", m_ah, 16'd4);
        chk("pol_locked_before_fs", 16'(plk_pre), 16'd0);
        chk("pol_locked_with_fs", 16'(plk_fs), 16'd1);
        chk("pol_aw", p_aw, 16'd8);
        chk("pol_ah", p_ah, 16'd4);

        send_frame(8, 4, 12, 7, 1, 12'h123);
        chk("f4_locked_at_fs", 16'(lk_fs), 16'd1);
        chk("short_locked_fall", 16'(lk_f1), 16'd1);
        chk("short_locked_next", 16'(lk_f2), 16'd0);
        chk("short_state", 16'(st_f2), 16'(SEARCH));
        chk("short_aw_kept", m_aw, 16'd8);
        chk("pol_short_locked", 16'(p_locked), 16'd0);

        send_frame(8, 4, 12, 7, -1, 12'h123);
        chk("f5_locked", 16'(lk_fs), 16'd0);
        send_frame(8, 4, 12, 7, -1, 12'h123);
        chk("f6_locked", 16'(lk_fs), 16'd0);
        send_frame(8, 4, 12, 7, -1, 12'h123);
        chk("f7_relocked", 16'(lk_fs), 16'd1);

        // Mid-line asynchronous reset
        vsync = 1'b0; hsync = 1'b0; de = 1'b1; {r_in, g_in, b_in} = 12'h456;
        tick(); tick(); tick();
        chk("pre_reset_pv", 16'(m_pv), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_x", m_x, 16'd0);
        chk("areset_pv", 16'(m_pv), 16'd0);
        chk("areset_r", 16'(m_r), 16'd0);
        chk("areset_locked", 16'(m_locked), 16'd0);
        chk("areset_aw", m_aw, 16'd0);
        chk("areset_ah", m_ah, 16'd0);
        de = 1'b0; {r_in, g_in, b_in} = 12'h000;
        tick();
        reset = 1'b0;
        tick();

        // de without any preceding vsync
        de = 1'b1; {r_in, g_in, b_in} = 12'h123;
        tick(); tick(); tick();
        de = 1'b0; {r_in, g_in, b_in} = 12'h000;
        tick(); tick();
        st_now = u_main.state_q;
        chk("novs_x", m_x, 16'd2);
        chk("novs_y", m_y, 16'd0);
        chk("novs_pv", 16'(m_pv), 16'd0);
        chk("novs_state", 16'(st_now), 16'(SEARCH));

        // 4x3 active, 8 clocks/line, 6 lines/frame (48 clocks, under the 64-clock timeout)
        send_frame(4, 3, 8, 6, -1, 12'h123);
        send_frame(4, 3, 8, 6, -1, 12'h123);
        send_frame(4, 3, 8, 6, -1, 12'h123);
        chk("tmo_locked_with_fs", 16'(tlk_fs), 16'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("tmo_locked_before", 16'(t_locked), 16'd1);
        for (int i = 0; i < 20; i++) tick();
        chk("tmo_locked_after", 16'(t_locked), 16'd0);
        chk("tmo_aw_kept", t_aw, 16'd4);
        chk("tmo_ah_kept", t_ah, 16'd3);

`ifdef VIDEO_SYNC_DECODER_CRC_EN
        crc_ref = ref_crc_zero(32);
        send_frame(8, 4, 12, 7, -1, 12'h000);
        send_frame(8, 4, 12, 7, -1, 12'h000);
        chk("crc_value", crc_fs, crc_ref);
        chk("crc_valid_pre", 16'(crcv_pre), 16'd0);
        chk("crc_valid_fs", 16'(crcv_fs), 16'd1);
        tick();
        chk("crc_valid_single", 16'(m_crcv), 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
